b02_line_serializer: RTL and testbench
======================================

Name: b02_line_serializer

Overview:
- Upstream feeder for the b02 serial recognizer FSM.
- Accepts parallel words (default 4-bit BCD digits) over a valid/ready handshake.
- Shifts each word out bit-serially on `linea`, one bit per clock, with a `linea_valid` qualifier and a frame-start strobe.
- Inserts a configurable idle gap between frames so the recognizer sees clean frame boundaries.

Parameters:
- WIDTH, 4, data bits per frame (≥1).
- GAP_CYCLES, 1, idle cycles between frames (≥0). During the gap, `linea`=0 and `linea_valid`=0.
- LSB_FIRST, 0, 0 = MSB transmitted first; 1 = LSB first.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  reset, synchronous, active-low
- in_data  in  WIDTH  parallel word to transmit
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word this cycle
- linea  out  1  serial line bit (registered), drives the recognizer's linea input
- linea_valid  out  1  linea carries a frame bit this cycle
- frame_start  out  1  high with the first bit of each frame
- busy  out  1  high in SHIFT or GAP state

Behaviour:
- Interface: one clock; reset is synchronous and active-low (reset_n sampled on the rising edge of clock).
- Reset values: state=IDLE, shift register=0, counters=0, linea=0, linea_valid=0, frame_start=0, busy=0. in_ready=1 once reset_n is high.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, load in_data, bit counter=0, go to SHIFT.
  - SHIFT: drive one bit per cycle; linea_valid=1; frame_start=1 only on counter 0.
    - After the last frame bit: go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: linea=0, linea_valid=0. Count GAP_CYCLES cycles, then go to IDLE.
- Latency: a word accepted at edge N has its first bit on linea after edge N, and its last data bit after edge N+WIDTH-1.
- Back-to-back (GAP_CYCLES=0 only):
  - in_ready is also high during the last SHIFT bit.
  - An accept there loads the next word; SHIFT continues with no idle cycle, and frame_start pulses on the new first bit.
- Ordering: LSB_FIRST=0 shifts left and outputs bit WIDTH-1 first. LSB_FIRST=1 shifts right and outputs bit 0 first.
- Counter widths:
  - bit counter is $clog2(WIDTH+2) bits, sized for the parity bit.
  - gap counter is $clog2(GAP_CYCLES+1) bits, minimum 1.
  - Neither counter wraps; both clear on state entry.
- in_data and in_valid are ignored when in_ready=0; no buffering and no overrun error.
- Reset asserted mid-frame: the next edge returns to IDLE, the partial frame is dropped, and all outputs take their reset values.
- All outputs are registered except in_ready, which is a combinational decode of state and counter.

Optional Feature:
- Macro: B02_SER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra frame bit = XOR of the loaded word (even parity), with linea_valid=1.
  - Frame length becomes WIDTH+1.
  - The back-to-back ready window moves to the parity bit.
- Undefined: frame is exactly WIDTH bits and no parity logic is generated.

Decomposition:
- Package b02_ser_pkg holds:
  - state enum {ST_IDLE, ST_SHIFT, ST_GAP}, 2-bit encoding
  - function for counter width (clog2 with minimum 1)
  - FRAME_LEN localparam expression, with parity adjustment
- One sub-module is natural: b02_ser_shreg, a parameterized load/shift register with direction select and a serial output bit.
- FSM and counters live in the top.

Test Plan:
- WIDTH=4, GAP=1: send 4'b1001 at edge 0.
  - linea after edges 0–3 = 1,0,0,1, with linea_valid=1 and frame_start only after edge 0.
  - After edge 4: GAP, linea=0, valid=0.
  - in_ready=1 again after edge 5.
- LSB_FIRST=1: send 4'b0011 → linea 1,1,0,0.
- GAP_CYCLES=0: in_valid held high with words 4'h5 then 4'hA → linea 0101 then 1010 contiguous, valid never drops, frame_start at bits 0 and 4.
- Apply reset_n=0 during bit 2 of 4'hF → next cycle linea=0, valid=0, busy=0, in_ready=1; no remaining bits emitted.
- in_data toggled while in_ready=0 → transmitted frame is unchanged.
- B02_SER_PARITY_EN with 4'b0111 → 5 valid bits 0,1,1,1,1.

Source files
------------

// File: rtl/b02_ser_pkg.sv
// Shared types and sizing helpers for the b02 line serializer.
// B02_SER_PARITY_EN appends one even-parity bit to every frame.
package b02_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

`ifdef B02_SER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits on the line per frame: data bits plus the optional parity bit.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/b02_ser_shreg.sv
// Parallel-load shift register with selectable direction.
// serial_o is the head bit the register will hold after the coming edge,
// so the owner can register it onto the line in the same cycle.
module b02_ser_shreg #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             serial_o
);

  logic [WIDTH-1:0] data_q, data_d;

  // Next contents: load wins over shift; zeros fill in behind the shift.
  always_comb begin
    // NOTE: default assigned first so no path leaves data_d unassigned (no latch).
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = LSB_FIRST ? (data_q >> 1) : (data_q << 1);
    end
  end

  assign serial_o = LSB_FIRST ? data_d[0] : data_d[WIDTH-1];

  // Storage, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: the data register is reset too, so no stale word survives a dropped frame.
      data_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/b02_line_serializer.sv
// Parallel-to-serial feeder for the b02 recognizer: accepts words over
// valid/ready, shifts them out on linea with a valid qualifier and a
// frame-start strobe, then idles GAP_CYCLES cycles between frames.
// Define B02_SER_PARITY_EN to append an even-parity bit to each frame.
module b02_line_serializer
  import b02_ser_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             linea,
  output logic             linea_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CW        = cnt_width(WIDTH + 2);
  localparam int GW        = cnt_width(GAP_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             linea_q, linea_d;
  logic             valid_q, valid_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             accept, sr_load, sr_shift, sr_serial, last_bit;

  // Ready in IDLE, and on the final frame bit when frames may abut.
  assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
  assign in_ready = (state_q == ST_IDLE) || ((GAP_CYCLES == 0) && last_bit);
  assign accept   = in_valid && in_ready;

  assign sr_load  = accept;
`ifdef B02_SER_PARITY_EN
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
  logic parity_q, parity_d;
  // Data bits remain only while the counter is below the last data index.
  assign sr_shift = (state_q == ST_SHIFT) && !accept && (bit_cnt_q < LAST_DATA);
`else
  assign sr_shift = (state_q == ST_SHIFT) && !accept && !last_bit;
`endif

  b02_ser_shreg #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_shreg (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (in_data),
    .serial_o(sr_serial)
  );

  // Next state, counters and the registered line outputs.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    linea_d   = 1'b0;
    valid_d   = 1'b0;
    start_d   = 1'b0;
`ifdef B02_SER_PARITY_EN
    parity_d  = parity_q;
`endif
    if (accept) begin
      state_d   = ST_SHIFT;
      bit_cnt_d = '0;
      linea_d   = sr_serial;
      valid_d   = 1'b1;
      start_d   = 1'b1;
`ifdef B02_SER_PARITY_EN
      parity_d  = ^in_data;
`endif
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SHIFT: begin
          if (last_bit) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            valid_d   = 1'b1;
`ifdef B02_SER_PARITY_EN
            linea_d   = sr_shift ? sr_serial : parity_q;
`else
            linea_d   = sr_serial;
`endif
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      linea_q   <= 1'b0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef B02_SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      linea_q   <= linea_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
`ifdef B02_SER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign linea       = linea_q;
  assign linea_valid = valid_q;
  assign frame_start = start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_b02_line_serializer.sv
// Bench for b02_line_serializer: three instances (MSB/gap1, LSB/gap2,
// MSB/gap0) checked every cycle against a queue-of-frame-bits model.
module tb_b02_line_serializer;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_data [3];
  logic [2:0]   in_valid = '0;
  logic [2:0]   in_ready, linea, linea_valid, frame_start, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each entry is one future line cycle. bit0=linea, bit1=data bit,
  // bit2=frame start, bit3=gap cycle. cur==0 means the block is idle.
  int q [3][$];
  int cur [3];
  bit last_acc [3];
  logic [15:0] cap [3];
  int ncap [3];
  int n2;

  always #5 clock = ~clock;

  b02_line_serializer #(.WIDTH(W), .GAP_CYCLES(1), .LSB_FIRST(1'b0)) u_msb (
    .clock(clock), .reset_n(reset_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .linea(linea[0]), .linea_valid(linea_valid[0]),
    .frame_start(frame_start[0]), .busy(busy[0]));

  b02_line_serializer #(.WIDTH(W), .GAP_CYCLES(2), .LSB_FIRST(1'b1)) u_lsb (
    .clock(clock), .reset_n(reset_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .linea(linea[1]), .linea_valid(linea_valid[1]),
    .frame_start(frame_start[1]), .busy(busy[1]));

  b02_line_serializer #(.WIDTH(W), .GAP_CYCLES(0), .LSB_FIRST(1'b0)) u_b2b (
    .clock(clock), .reset_n(reset_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .linea(linea[2]), .linea_valid(linea_valid[2]),
    .frame_start(frame_start[2]), .busy(busy[2]));

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 0;
  endfunction

  function automatic bit lsb_of(input int i);
    return (i == 1);
  endfunction

  // Idle, or showing the final bit of a frame with nothing queued behind it
  // when frames are allowed to abut.
  function automatic bit model_ready(input int i);
    return (cur[i] == 0) || (gap_of(i) == 0 && cur[i][1] && q[i].size() == 0);
  endfunction

  function automatic void push_frame(input int i, input logic [W-1:0] w);
    bit b;
    for (int k = 0; k < W; k++) begin
      b = lsb_of(i) ? w[k] : w[W-1-k];
      q[i].push_back(2 | int'(b) | ((k == 0) ? 4 : 0));
    end
`ifdef B02_SER_PARITY_EN
    q[i].push_back(2 | int'(^w));
`endif
    for (int g = 0; g < gap_of(i); g++) q[i].push_back(8);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock: predict acceptance, advance the model, then compare outputs.
  task automatic tick();
    bit acc [3];
    for (int i = 0; i < 3; i++) acc[i] = in_valid[i] && model_ready(i);
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) q[i].delete();
      else if (acc[i]) push_frame(i, in_data[i]);
      cur[i] = (q[i].size() > 0) ? q[i].pop_front() : 0;
      last_acc[i] = acc[i] && reset_n;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("linea[%0d]", i),       32'(linea[i]),       32'(cur[i][0]));
      check($sformatf("linea_valid[%0d]", i), 32'(linea_valid[i]), 32'(cur[i][1]));
      check($sformatf("frame_start[%0d]", i), 32'(frame_start[i]), 32'(cur[i][2]));
      check($sformatf("busy[%0d]", i),        32'(busy[i]),        32'(cur[i] != 0));
      check($sformatf("in_ready[%0d]", i),    32'(in_ready[i]),    32'(model_ready(i)));
      if (linea_valid[i]) begin
        cap[i] = {cap[i][14:0], linea[i]};
        ncap[i]++;
      end
    end
  endtask

  task automatic clear_caps();
    for (int i = 0; i < 3; i++) begin
      cap[i] = '0;
      ncap[i] = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_data[i] = '0;
      cur[i] = 0;
    end
    reset_n = 1'b0;
    #1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Directed: 1001 MSB-first, 0011 LSB-first, 5 then A back-to-back.
    clear_caps();
    in_data[0] = 4'b1001; in_valid[0] = 1'b1;
    in_data[1] = 4'b0011; in_valid[1] = 1'b1;
    in_data[2] = 4'h5;    in_valid[2] = 1'b1;
    n2 = 0;
    for (int t = 0; t < 14; t++) begin
      tick();
      if (last_acc[2]) n2++;
      in_valid[0] = 1'b0; in_data[0] = 4'($urandom);
      in_valid[1] = 1'b0; in_data[1] = 4'($urandom);
      in_data[2]  = (n2 == 0) ? 4'h5 : 4'hA;
      in_valid[2] = (n2 < 2);
    end
`ifdef B02_SER_PARITY_EN
    check("msb_bits",  32'(cap[0][4:0]), 32'b10010);
    check("msb_count", 32'(ncap[0]), 5);
    check("lsb_bits",  32'(cap[1][4:0]), 32'b11000);
    check("b2b_bits",  32'(cap[2][9:0]), 32'b0101010100);
    check("b2b_count", 32'(ncap[2]), 10);
`else
    check("msb_bits",  32'(cap[0][3:0]), 32'b1001);
    check("msb_count", 32'(ncap[0]), 4);
    check("lsb_bits",  32'(cap[1][3:0]), 32'b1100);
    check("b2b_bits",  32'(cap[2][7:0]), 32'b01011010);
    check("b2b_count", 32'(ncap[2]), 8);
`endif

    // Reset during bit 2 of 4'hF drops the rest of the frame.
    clear_caps();
    in_data[0] = 4'hF; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("rst_linea", 32'(linea[0]), 0);
    check("rst_valid", 32'(linea_valid[0]), 0);
    check("rst_busy",  32'(busy[0]), 0);
    check("rst_ready", 32'(in_ready[0]), 1);
    reset_n = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    check("rst_dropped", 32'(ncap[0]), 3);

`ifdef B02_SER_PARITY_EN
    clear_caps();
    in_data[0] = 4'b0111; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int t = 0; t < 7; t++) tick();
    check("par_bits",  32'(cap[0][4:0]), 32'b01111);
    check("par_count", 32'(ncap[0]), 5);
`endif

    // Random traffic with data churning every cycle and rare resets.
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < 3; i++) begin
        in_data[i]  = 4'($urandom);
        in_valid[i] = ($urandom_range(0, 3) != 0);
      end
      reset_n = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
